// File: rtl/isp_pixel_io_pkg.sv
// Shared types and constants for the ISP pixel I/O block: FSM states,
// register word indices and CTRL/STATUS bit positions.
package isp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_STREAM   = 2'd2,
        ST_DRAIN    = 2'd3
    } isp_state_t;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_FRAME  = 3'd2;
    localparam logic [2:0] REG_LINE   = 3'd3;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_TPG      = 1;
    localparam int unsigned CTRL_MASK_N   = 2;
    localparam int unsigned CTRL_CLR      = 3;
    localparam int unsigned STAT_OVF      = 8;
    localparam int unsigned STAT_STATE_LO = 9;

endpackage

// File: rtl/isp_pixel_io_if.sv
// Word-addressed register bus between the management SoC (master) and
// the ISP pixel I/O block (slave).
interface isp_pixel_io_if;
    logic        valid;
    logic [3:0]  wstrb;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, wstrb, addr, wdata, input ready, rdata);
    modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/isp_pixel_io_fifo.sv
// First-word-fall-through synchronous FIFO with exact level and a
// synchronous clear that overrides push and pop.
module isp_sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/isp_pixel_io.sv
// ISP pixel I/O slave: sensor stream -> FIFO -> pad bus, with frame/line
// counters, register port and interrupt. Optional TPG: ISP_PIXEL_IO_TPG_EN.
module isp_pixel_io import isp_pkg::*; #(
    parameter int unsigned BITS  = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    isp_pixel_io_if.slave     bus,
    input  logic              pix_valid_i,
    input  logic [BITS-1:0]   pix_data_i,
    input  logic              pix_sof_i,
    input  logic              pix_eol_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [BITS-1:0]   out_data_o,
    output logic              irq_o
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    isp_state_t         state, state_nxt;
    logic               en, mask_n, ovf, tpg_bit;
    logic [CNT_W-1:0]   frame_cnt, line_cnt;
    logic [LW-1:0]      level;
    logic               full, empty;
    logic               acc, ctrl_wr, clr, ovf_wclr;
    logic               beat_valid, beat_sof, beat_eol;
    logic [BITS-1:0]    beat_data;
    logic               take, push, pop, drop;
    logic [31:0]        rd_mux;

    assign acc      = bus.valid && !bus.ready;
    assign ctrl_wr  = acc && (bus.addr == REG_CTRL) && bus.wstrb[0];
    assign clr      = ctrl_wr && bus.wdata[CTRL_CLR];
    assign ovf_wclr = acc && (bus.addr == REG_STATUS) && bus.wstrb[1] && bus.wdata[STAT_OVF];

`ifdef ISP_PIXEL_IO_TPG_EN
    logic            tpg_on;
    logic [BITS-1:0] tpg_cnt;

    // The pattern also drives WAIT_SOF so its own sof beat opens the frame.
    assign tpg_on = tpg_bit && (state == ST_WAIT_SOF || state == ST_STREAM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       tpg_cnt <= '0;
        else if (!tpg_on) tpg_cnt <= '0;
        else if (push)    tpg_cnt <= tpg_cnt + BITS'(1);
    end

    always_comb begin
        beat_valid = tpg_on ? 1'b1 : pix_valid_i;
        beat_data  = tpg_on ? tpg_cnt : pix_data_i;
        beat_sof   = tpg_on ? (tpg_cnt == '0) : pix_sof_i;
        beat_eol   = tpg_on ? (tpg_cnt[5:0] == 6'h3f) : pix_eol_i;
    end
`else
    assign tpg_bit    = 1'b0;
    assign beat_valid = pix_valid_i;
    assign beat_data  = pix_data_i;
    assign beat_sof   = pix_sof_i;
    assign beat_eol   = pix_eol_i;
`endif

    assign take        = beat_valid && (state == ST_STREAM || (state == ST_WAIT_SOF && beat_sof));
    assign out_valid_o = !empty;
    assign pop         = out_valid_o && out_ready_i;
    assign push        = take && (!full || pop) && !clr;
    assign drop        = take && full && !pop;

    isp_sync_fifo #(.WIDTH(BITS), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clr),
        .push  (push),
        .pop   (pop),
        .wdata (beat_data),
        .rdata (out_data_o),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (en) state_nxt = ST_WAIT_SOF;
            ST_WAIT_SOF: if (!en) state_nxt = ST_IDLE;
                         else if (push) state_nxt = ST_STREAM;
            ST_STREAM:   if (!en) state_nxt = ST_DRAIN;
            ST_DRAIN:    if (empty) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            REG_CTRL: begin
                rd_mux[CTRL_EN]     = en;
                rd_mux[CTRL_TPG]    = tpg_bit;
                rd_mux[CTRL_MASK_N] = mask_n;
            end
            REG_STATUS: begin
                rd_mux[LW-1:0]              = level;
                rd_mux[STAT_OVF]            = ovf;
                rd_mux[STAT_STATE_LO +: 2]  = state;
            end
            REG_FRAME: rd_mux[CNT_W-1:0] = frame_cnt;
            REG_LINE:  rd_mux[CNT_W-1:0] = line_cnt;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ready <= 1'b0;
            bus.rdata <= '0;
            en        <= 1'b0;
            mask_n    <= 1'b0;
            ovf       <= 1'b0;
            frame_cnt <= '0;
            line_cnt  <= '0;
            irq_o     <= 1'b0;
        end else begin
            bus.ready <= acc;
            if (acc) bus.rdata <= rd_mux;
            if (ctrl_wr) begin
                en     <= bus.wdata[CTRL_EN];
                mask_n <= bus.wdata[CTRL_MASK_N];
            end
            if (clr || ovf_wclr) ovf <= 1'b0;
            else if (drop)       ovf <= 1'b1;
            if (clr) begin
                frame_cnt <= '0;
                line_cnt  <= '0;
            end else if (push) begin
                if (beat_sof) begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                    line_cnt  <= beat_eol ? CNT_W'(1) : '0;
                end else if (beat_eol) begin
                    line_cnt <= line_cnt + CNT_W'(1);
                end
            end
            irq_o <= ovf & mask_n;
        end
    end

`ifdef ISP_PIXEL_IO_TPG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       tpg_bit <= 1'b0;
        else if (ctrl_wr) tpg_bit <= bus.wdata[CTRL_TPG];
    end
`endif
endmodule

// File: doc/isp_pixel_io.md
Name: isp_pixel_io

Overview:
Parametrised successor to the single-counter ISP I/O slave. Accepts a parallel pixel stream from the sensor interface, buffers it in a DEPTH-entry FIFO, and drives it to the pad-side output bus with a valid/ready handshake. Tracks frame and line counts, reports status and a sticky overflow through a word-addressed Wishbone-style register port, and raises an interrupt. Instantiated inside user_proj_example between the IO pads and the management SoC.

Parameters:
BITS, 16, pixel data width (8..32)
DEPTH, 8, FIFO entries; power of two, at least 2
CNT_W, 16, width of the frame and line counters (at most 32)

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
valid  in  1  register access strobe (cyc & stb)
wstrb  in  4  byte write enables; all zero = read
addr  in  3  register word index
wdata  in  32  write data
ready  out  1  access acknowledge, one-cycle pulse
rdata  out  32  read data; unused upper bits are 0
pix_valid_i  in  1  sensor beat valid
pix_data_i  in  BITS  sensor pixel
pix_sof_i  in  1  start of frame, qualified by pix_valid_i
pix_eol_i  in  1  end of line, qualified by pix_valid_i
out_valid_o  out  1  output beat valid
out_ready_i  in  1  output sink ready
out_data_o  out  BITS  output pixel
irq_o  out  1  level interrupt

Behaviour:
- Reset: ready=0, rdata=0, out_valid_o=0, out_data_o=0, irq_o=0, FIFO empty, counters 0, CTRL=0, FSM=IDLE.
- Register map (word index):
  - 0 CTRL (RW): bit0 EN; bit1 TPG; bit2 IRQ_MASK_N; bit3 CLR (self-clearing).
  - 1 STATUS (RO; a write of bit8=1 clears OVF): [log2(DEPTH):0] level; bit8 OVF (sticky); [10:9] FSM state.
  - 2 FRAME_CNT (RO).
  - 3 LINE_CNT (RO).
  - Any other index reads 0; writes to it are ignored.
- Register port:
  - When valid && !ready: ready=1 on the next edge and rdata is captured on that same edge.
  - Writes honour wstrb per byte.
  - Back-to-back accesses are acknowledged every other cycle.
- FSM:
  - IDLE(0) -> WAIT_SOF(1) when EN=1.
  - WAIT_SOF -> STREAM(2) on an accepted beat with sof. That sof beat is pushed.
  - Beats arriving in WAIT_SOF without sof are discarded and not counted.
  - STREAM -> DRAIN(3) when EN=0.
  - DRAIN: input discarded; FIFO keeps emptying; -> IDLE when the FIFO is empty.
  - In IDLE and WAIT_SOF, EN=0 -> IDLE immediately.
- Input: there is no backpressure (the sensor cannot stall).
  - In STREAM, a beat is pushed if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the beat is dropped and OVF is set.
- Output: out_valid_o = FIFO not empty; out_data_o = head of FIFO; pop when out_valid_o && out_ready_i.
- FIFO is first-word-fall-through.
  - Latency: a beat pushed at edge N is visible at the output after edge N.
  - Level is exact under simultaneous push/pop.
- Counters:
  - FRAME_CNT += 1 on every pushed sof beat. It wraps modulo 2^CNT_W.
  - LINE_CNT is reset to 0 on a pushed sof beat.
  - Otherwise LINE_CNT += 1 on a pushed eol beat. It wraps modulo 2^CNT_W.
  - A beat with both sof and eol: FRAME_CNT+1 and LINE_CNT=1.
  - Dropped beats do not affect the counters.
- CLR: empties the FIFO and zeroes both counters and OVF on the write edge; it does not change the FSM.
  - CLR overrides any push or pop in the same cycle.
- irq_o = OVF & IRQ_MASK_N, registered.
- Reset asserted mid-frame: everything returns to the reset values asynchronously; the FIFO contents are invalid.

Optional Feature:
Macro ISP_PIXEL_IO_TPG_EN.
- Defined: with CTRL.TPG=1 in STREAM, the sensor input is ignored and an internal BITS-wide counter is pushed instead.
  - The counter starts at 0 on entry to STREAM and increments on each successful push.
  - A push is attempted every cycle.
  - The first pattern beat carries sof, and every 64th beat carries eol.
- Not defined: TPG is tied to 0, CTRL bit1 reads 0, and no counter logic is generated.

Decomposition:
- Package isp_pkg:
  - FSM state encoding (IDLE/WAIT_SOF/STREAM/DRAIN = 0..3);
  - register index constants (REG_CTRL=0, REG_STATUS=1, REG_FRAME=2, REG_LINE=3);
  - CTRL/STATUS bit positions.
- One sub-module, isp_sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/level, FWFT, synchronous clear). The top level holds the register port, FSM, counters and TPG.

Test Plan:
- Reset, then read STATUS -> rdata=0x0; ready pulses for exactly 1 cycle, 1 cycle after valid.
- EN=1; 3 junk beats; then sof beat 0x0011, beat 0x0022, eol beat 0x0033; out_ready_i=1 -> output sequence 0x0011, 0x0022, 0x0033; FRAME_CNT=1, LINE_CNT=1; the junk beats do not appear at the output.
- out_ready_i=0, push DEPTH+2=10 beats in STREAM -> level=8, OVF=1, irq_o=1 (mask set); the first 8 beats come out in order.
- FIFO full with out_ready_i=1 and a simultaneous push -> no drop, OVF stays 0, level stays 8.
- Write EN=0 with 5 entries queued -> state DRAIN, 5 beats are output, then state IDLE; new beats are ignored.
- (TPG build) CTRL=0x3 -> output 0x0000, 0x0001, 0x0002...; FRAME_CNT=1; LINE_CNT=1 after 64 beats.
